// File: rtl/matrix_result_reader_pkg.sv
// Shared types for the matrix result reader and the multiplier bench RAM model.
// Beat struct gains a row_last flag when MATRIX_RESULT_READER_ROW_LAST_EN is defined.
package matrix_pkg;

    localparam int READ_LATENCY          = 1;
    localparam int MULT_RAM_READ_LATENCY = READ_LATENCY;
    localparam int BEAT_DATA_WIDTH       = 32;
    localparam int BEAT_ADDR_WIDTH       = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } reader_state_e;

    typedef struct packed {
        logic [BEAT_DATA_WIDTH-1:0] data;
        logic [BEAT_ADDR_WIDTH-1:0] row;
        logic [BEAT_ADDR_WIDTH-1:0] col;
        logic                       last;
`ifdef MATRIX_RESULT_READER_ROW_LAST_EN
        logic                       row_last;
`endif
    } beat_t;

endpackage

// File: rtl/matrix_result_reader_if.sv
// Result-RAM read port plus the valid/ready element stream of the result reader.
// m_row_last exists only when MATRIX_RESULT_READER_ROW_LAST_EN is defined.
interface matrix_result_reader_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  z_rd_en;
    logic [ADDR_WIDTH-1:0] z_rd_addr;
    logic [DATA_WIDTH-1:0] z_rd_data;
    logic [DATA_WIDTH-1:0] m_data;
    logic [ADDR_WIDTH-1:0] m_row;
    logic [ADDR_WIDTH-1:0] m_col;
    logic                  m_last;
    logic                  m_valid;
    logic                  m_ready;
`ifdef MATRIX_RESULT_READER_ROW_LAST_EN
    logic                  m_row_last;
`endif

    modport master (
        output z_rd_en,
        output z_rd_addr,
        input  z_rd_data,
        output m_data,
        output m_row,
        output m_col,
        output m_last,
`ifdef MATRIX_RESULT_READER_ROW_LAST_EN
        output m_row_last,
`endif
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  z_rd_en,
        input  z_rd_addr,
        output z_rd_data,
        input  m_data,
        input  m_row,
        input  m_col,
        input  m_last,
`ifdef MATRIX_RESULT_READER_ROW_LAST_EN
        input  m_row_last,
`endif
        input  m_valid,
        output m_ready
    );

endinterface

// File: rtl/matrix_result_reader_result_fifo2.sv
// Two-entry synchronous FIFO of result beats; push when full is accepted only alongside a pop.
module result_fifo2
    import matrix_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  beat_t      beat,
    output beat_t      head,
    output logic [1:0] count,
    output logic       full,
    output logic       empty
);

    beat_t      mem_r [2];
    logic       wr_ptr_r;
    logic       rd_ptr_r;
    logic [1:0] count_r;
    logic       push_ok_s;
    logic       pop_ok_s;

    // Qualify requests so a misbehaving producer or consumer cannot corrupt state.
    always_comb begin
        pop_ok_s  = pop && (count_r != 2'd0);
        push_ok_s = push && ((count_r != 2'd2) || pop_ok_s);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_r[0] <= '0;
            mem_r[1] <= '0;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= beat;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = (count_r == 2'd2);
    assign empty = (count_r == 2'd0);

endmodule

// File: rtl/matrix_result_reader.sv
// Streams the Z result matrix row-major from the result RAM as tagged valid/ready beats.
// Optional m_row_last flag enabled by MATRIX_RESULT_READER_ROW_LAST_EN.
module matrix_result_reader
    import matrix_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int Z_ROWS     = 5,
    parameter int Z_COLS     = 5,
    parameter int BASE_ADDR  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    matrix_result_reader_if.master bus
);

    reader_state_e         state_r;
    reader_state_e         state_nxt_s;
    logic [ADDR_WIDTH-1:0] row_r;
    logic [ADDR_WIDTH-1:0] col_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [ADDR_WIDTH-1:0] addr_hold_r;
    logic                  inflight_r;
    logic [ADDR_WIDTH-1:0] tag_row_r;
    logic [ADDR_WIDTH-1:0] tag_col_r;
    logic                  tag_last_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  rd_en_s;
    logic                  pop_s;
    logic                  col_end_s;
    logic                  issue_last_s;
    logic                  last_pop_s;
    logic [2:0]            pending_s;
    beat_t                 push_beat_s;
    beat_t                 head_s;
    logic [1:0]            fifo_count_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;

    // Issue decision: reads are only launched when the FIFO is sure to have room on return.
    always_comb begin
        pop_s        = !fifo_empty_s && bus.m_ready;
        pending_s    = {1'b0, fifo_count_s} + {2'b00, inflight_r} - {2'b00, pop_s};
        col_end_s    = (col_r == ADDR_WIDTH'(Z_COLS - 1));
        issue_last_s = col_end_s && (row_r == ADDR_WIDTH'(Z_ROWS - 1));
        rd_en_s      = (state_r == ST_READ) && (pending_s < 3'd2) && (!fifo_full_s || pop_s);
        last_pop_s   = pop_s && head_s.last;
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nxt_s = ST_READ;
                else       state_nxt_s = ST_IDLE;
            end
            ST_READ: begin
                if (rd_en_s && issue_last_s) state_nxt_s = ST_DRAIN;
                else                         state_nxt_s = ST_READ;
            end
            ST_DRAIN: begin
                if (last_pop_s) state_nxt_s = ST_IDLE;
                else            state_nxt_s = ST_DRAIN;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            done_r  <= (state_r == ST_DRAIN) && last_pop_s;
        end
    end

    // Row/column/address counters; the address steps by one so no multiplier is needed.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_r       <= '0;
            col_r       <= '0;
            addr_r      <= '0;
            addr_hold_r <= '0;
        end else if ((state_r == ST_IDLE) && start) begin
            row_r  <= '0;
            col_r  <= '0;
            addr_r <= ADDR_WIDTH'(BASE_ADDR);
        end else if (rd_en_s) begin
            addr_hold_r <= addr_r;
            addr_r      <= addr_r + ADDR_WIDTH'(1);
            if (col_end_s) begin
                col_r <= '0;
                row_r <= row_r + ADDR_WIDTH'(1);
            end else begin
                col_r <= col_r + ADDR_WIDTH'(1);
            end
        end else begin
            addr_hold_r <= addr_hold_r;
        end
    end

    // Tag pipe: indices travel one cycle alongside the RAM read they describe.
`ifdef MATRIX_RESULT_READER_ROW_LAST_EN
    logic tag_row_last_r;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_r     <= 1'b0;
            tag_row_r      <= '0;
            tag_col_r      <= '0;
            tag_last_r     <= 1'b0;
`ifdef MATRIX_RESULT_READER_ROW_LAST_EN
            tag_row_last_r <= 1'b0;
`endif
        end else begin
            inflight_r <= rd_en_s;
            if (rd_en_s) begin
                tag_row_r      <= row_r;
                tag_col_r      <= col_r;
                tag_last_r     <= issue_last_s;
`ifdef MATRIX_RESULT_READER_ROW_LAST_EN
                tag_row_last_r <= col_end_s;
`endif
            end
        end
    end

    // Assemble the beat from the returning RAM word and its tag.
    always_comb begin
        push_beat_s          = '0;
        push_beat_s.data     = BEAT_DATA_WIDTH'(bus.z_rd_data);
        push_beat_s.row      = BEAT_ADDR_WIDTH'(tag_row_r);
        push_beat_s.col      = BEAT_ADDR_WIDTH'(tag_col_r);
        push_beat_s.last     = tag_last_r;
`ifdef MATRIX_RESULT_READER_ROW_LAST_EN
        push_beat_s.row_last = tag_row_last_r;
`endif
    end

    result_fifo2 u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight_r),
        .pop   (pop_s),
        .beat  (push_beat_s),
        .head  (head_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign bus.z_rd_en    = rd_en_s;
    assign bus.z_rd_addr  = rd_en_s ? addr_r : addr_hold_r;
    assign bus.m_valid    = !fifo_empty_s;
    assign bus.m_data     = DATA_WIDTH'(head_s.data);
    assign bus.m_row      = ADDR_WIDTH'(head_s.row);
    assign bus.m_col      = ADDR_WIDTH'(head_s.col);
    assign bus.m_last     = head_s.last;
`ifdef MATRIX_RESULT_READER_ROW_LAST_EN
    assign bus.m_row_last = head_s.row_last;
`endif
    assign busy           = busy_r;
    assign done           = done_r;

endmodule

// File: tb/tb_matrix_result_reader.sv
// Directed self-checking bench for matrix_result_reader, 2x3 matrix at base address 16.
module tb_matrix_result_reader;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NB = 6;

    typedef struct {
        logic [31:0] d;
        logic [31:0] r;
        logic [31:0] c;
        logic        l;
        logic        rl;
    } rec_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic done;

    matrix_result_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    matrix_result_reader #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .Z_ROWS     (2),
        .Z_COLS     (3),
        .BASE_ADDR  (16)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [64];
    always @(posedge clk) begin
        if (bus.z_rd_en) bus.z_rd_data <= mem[bus.z_rd_addr[5:0]];
    end

    int assert_cnt = 0;
    int fail_cnt   = 0;
    int cyc        = 0;
    int done_cnt   = 0;
    int outstanding = 0;
    logic [31:0] rd_q[$];
    int          rd_cyc_q[$];
    rec_t        beat_q[$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data, prev_row, prev_col;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        assert_cnt++;
        if (obs !== expv) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Passive monitor: records reads, beats and done pulses; checks stall stability and occupancy.
    always @(negedge clk) begin
        if (rst) begin
            outstanding = 0;
            prev_stall  = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("stall_valid", {63'd0, bus.m_valid}, 64'd1);
                check_eq("stall_data", {32'd0, bus.m_data}, {32'd0, prev_data});
                check_eq("stall_rowcol", {bus.m_row, bus.m_col}, {prev_row, prev_col});
            end
            if (bus.z_rd_en) begin
                rd_q.push_back(bus.z_rd_addr);
                rd_cyc_q.push_back(cyc);
                outstanding++;
            end
            if (bus.m_valid && bus.m_ready) begin
                rec_t b;
                b.d = bus.m_data; b.r = bus.m_row; b.c = bus.m_col; b.l = bus.m_last;
`ifdef MATRIX_RESULT_READER_ROW_LAST_EN
                b.rl = bus.m_row_last;
`else
                b.rl = 1'b0;
`endif
                beat_q.push_back(b);
                outstanding--;
            end
            if (bus.z_rd_en) check_eq("occupancy_le2", {63'd0, outstanding <= 2}, 64'd1);
            if (done) begin
                done_cnt++;
                check_eq("done_busy_low", {63'd0, busy}, 64'd0);
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
            prev_row   = bus.m_row;
            prev_col   = bus.m_col;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_logs();
        rd_q.delete();
        rd_cyc_q.delete();
        beat_q.delete();
        done_cnt = 0;
    endtask

    task automatic verify_seq(input string name);
        check_eq({name, "_beat_count"}, beat_q.size(), NB);
        for (int i = 0; i < NB && i < beat_q.size(); i++) begin
            check_eq({name, "_data"}, {32'd0, beat_q[i].d}, 64'(10 + i));
            check_eq({name, "_row"}, {32'd0, beat_q[i].r}, 64'(i / 3));
            check_eq({name, "_col"}, {32'd0, beat_q[i].c}, 64'(i % 3));
            check_eq({name, "_last"}, {63'd0, beat_q[i].l}, {63'd0, i == NB - 1});
`ifdef MATRIX_RESULT_READER_ROW_LAST_EN
            check_eq({name, "_row_last"}, {63'd0, beat_q[i].rl}, {63'd0, (i % 3) == 2});
`endif
        end
        check_eq({name, "_done_count"}, done_cnt, 1);
        check_eq({name, "_read_count"}, rd_q.size(), NB);
        check_eq({name, "_idle_busy"}, {63'd0, busy}, 64'd0);
        check_eq({name, "_idle_valid"}, {63'd0, bus.m_valid}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hDEAD_0000 + 32'(i);
        for (int i = 0; i < NB; i++) mem[16 + i] = 32'(10 + i);
        rst         = 1'b1;
        start       = 1'b0;
        bus.m_ready = 1'b1;
        repeat (3) tick();

        // Reset state, including start coincident with reset.
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_done", {63'd0, done}, 64'd0);
        check_eq("rst_valid", {63'd0, bus.m_valid}, 64'd0);
        check_eq("rst_rd_en", {63'd0, bus.z_rd_en}, 64'd0);
        check_eq("rst_data", {32'd0, bus.m_data}, 64'd0);
        rst = 1'b0;
        tick();
        check_eq("rst_start_ignored", {63'd0, busy}, 64'd0);

        // Test 1: full-rate readout and first-beat latency.
        clear_logs();
        bus.m_ready = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check_eq("lat_rd_en", {63'd0, bus.z_rd_en}, 64'd1);
        check_eq("lat_addr", {32'd0, bus.z_rd_addr}, 64'd16);
        check_eq("lat_busy", {63'd0, busy}, 64'd1);
        check_eq("lat_valid_n1", {63'd0, bus.m_valid}, 64'd0);
        @(negedge clk);
        check_eq("lat_valid_n2", {63'd0, bus.m_valid}, 64'd0);
        @(negedge clk);
        check_eq("lat_valid_n3", {63'd0, bus.m_valid}, 64'd1);
        check_eq("lat_first_data", {32'd0, bus.m_data}, 64'd10);
        repeat (30) tick();
        verify_seq("t1");
        for (int i = 0; i < NB && i < rd_q.size(); i++) begin
            check_eq("t1_addr", {32'd0, rd_q[i]}, 64'(16 + i));
            check_eq("t1_addr_cycle", 64'(rd_cyc_q[i] - rd_cyc_q[0]), 64'(i));
        end

        // Test 2: ready toggling every cycle.
        clear_logs();
        bus.m_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 40; i++) begin
            bus.m_ready = ~bus.m_ready;
            tick();
        end
        bus.m_ready = 1'b1;
        tick();
        verify_seq("t2");

        // Test 3: backpressure for 10 cycles after start.
        clear_logs();
        bus.m_ready = 1'b0;
        pulse_start();
        repeat (10) tick();
        check_eq("t3_reads_while_stalled", rd_q.size(), 2);
        check_eq("t3_rd_en_low", {63'd0, bus.z_rd_en}, 64'd0);
        check_eq("t3_valid_held", {63'd0, bus.m_valid}, 64'd1);
        check_eq("t3_head_data", {32'd0, bus.m_data}, 64'd10);
        bus.m_ready = 1'b1;
        repeat (30) tick();
        verify_seq("t3");

        // Test 4: reset while the third beat is on the output.
        clear_logs();
        bus.m_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 20 && beat_q.size() < 2; i++) tick();
        check_eq("t4_two_beats", beat_q.size(), 2);
        rst = 1'b1;
        tick();
        check_eq("t4_valid_after_rst", {63'd0, bus.m_valid}, 64'd0);
        check_eq("t4_busy_after_rst", {63'd0, busy}, 64'd0);
        rst = 1'b0;
        repeat (10) tick();
        check_eq("t4_no_done", done_cnt, 0);
        check_eq("t4_no_third_beat", beat_q.size(), 2);
        clear_logs();
        pulse_start();
        repeat (30) tick();
        verify_seq("t4_restart");

        // Test 5: extra start pulse while busy.
        clear_logs();
        pulse_start();
        repeat (2) tick();
        check_eq("t5_busy", {63'd0, busy}, 64'd1);
        pulse_start();
        repeat (30) tick();
        verify_seq("t5");

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
